// File: rtl/keystone_pkg.sv
// rtl/keystone_pkg.sv - shared types and width helpers for the keystone frame regulator
package keystone_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } regulator_state_t;

    typedef enum logic {
        PAD_LINE  = 1'b0,
        PAD_FRAME = 1'b1
    } pad_mode_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_video_out_reg.sv
// rtl/axis_video_out_reg.sv - one-stage clock-enabled register slice for video beats
module axis_video_out_reg
    import keystone_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    output logic              load_en,
    input  logic              up_tvalid,
    input  logic [DATA_W-1:0] up_tdata,
    input  logic              up_tuser,
    input  logic              up_tlast,
    input  logic              dn_tready,
    output logic              dn_tvalid,
    output logic [DATA_W-1:0] dn_tdata,
    output logic              dn_tuser,
    output logic              dn_tlast
);

    // The slot can take a new beat when it is empty or being drained this cycle
    assign load_en = aclken & (~dn_tvalid | dn_tready);

    // Output slot: payload only changes when a real beat is loaded
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dn_tvalid <= 1'b0;
            dn_tdata  <= '0;
            dn_tuser  <= 1'b0;
            dn_tlast  <= 1'b0;
        end else if (load_en) begin
            dn_tvalid <= up_tvalid;
            if (up_tvalid) begin
                dn_tdata <= up_tdata;
                dn_tuser <= up_tuser;
                dn_tlast <= up_tlast;
            end
        end
    end

endmodule

// File: rtl/keystone_frame_regulator.sv
// rtl/keystone_frame_regulator.sv - forces exact line/frame geometry on an RGB video stream
module keystone_frame_regulator
    import keystone_pkg::*;
#(
    parameter int                DATA_W     = PIX_W,
    parameter int                H_ACTIVE   = 1280,
    parameter int                V_ACTIVE   = 720,
    parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    input  logic [DATA_W-1:0] s_axis_video_tdata_in,
    input  logic              s_axis_video_tvalid_in,
    output logic              s_axis_video_tready_out,
    input  logic              s_axis_video_tuser_in,
    input  logic              s_axis_video_tlast_in,
    output logic [DATA_W-1:0] m_axis_video_tdata_out,
    output logic              m_axis_video_tvalid_out,
    input  logic              m_axis_video_tready_in,
    output logic              m_axis_video_tuser_out,
    output logic              m_axis_video_tlast_out,
    output logic              err_short_line,
    output logic              err_long_line,
    output logic              err_short_frame,
    output logic              err_long_frame
);

    localparam int             X_W   = cnt_w(H_ACTIVE);
    localparam int             Y_W   = cnt_w(V_ACTIVE);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    regulator_state_t  state, nxt_state;
    pad_mode_t         pad_mode, nxt_mode;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              load_en;
    logic              emit;
    logic [DATA_W-1:0] emit_data;
    logic              at_origin, x_last, y_last;
    logic              e_sl, e_ll, e_sf, e_lf;
    logic              resync, drop_end;

    assign at_origin = (x == '0) && (y == '0);
    assign x_last    = (x == X_MAX);
    assign y_last    = (y == Y_MAX);

    // State and pad mode advance only while the clock enable is high
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= SEEK;
            pad_mode <= PAD_LINE;
        end else if (aclken) begin
            state    <= nxt_state;
            pad_mode <= nxt_mode;
        end
    end

    // Classify the beat at the input (or the pad slot) and decide what is emitted
    always_comb begin
        s_axis_video_tready_out = 1'b0;
        emit      = 1'b0;
        emit_data = s_axis_video_tdata_in;
        e_sl      = 1'b0;
        e_ll      = 1'b0;
        e_sf      = 1'b0;
        e_lf      = 1'b0;
        resync    = 1'b0;
        drop_end  = 1'b0;
        unique case (state)
            SEEK: begin
                s_axis_video_tready_out = load_en;
                if (load_en && s_axis_video_tvalid_in && s_axis_video_tuser_in) begin
                    emit = 1'b1;
                    e_sl = s_axis_video_tlast_in;
                end
            end
            PASS: begin
                // An early start-of-frame is left waiting at the input while the frame is padded out
                if (s_axis_video_tvalid_in && s_axis_video_tuser_in && !at_origin) begin
                    e_sf = load_en;
                end else begin
                    s_axis_video_tready_out = load_en;
                    if (load_en && s_axis_video_tvalid_in) begin
                        if (s_axis_video_tlast_in && !x_last) begin
                            emit = 1'b1;
                            e_sl = 1'b1;
                        end else if (!s_axis_video_tlast_in && x_last) begin
                            emit = 1'b1;
                            e_ll = 1'b1;
                        end else if (at_origin && !s_axis_video_tuser_in) begin
                            e_lf = 1'b1;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                emit      = load_en;
                emit_data = FILL_COLOR;
            end
            DROP: begin
                // A start-of-frame ends the drop; only mid-frame is it a short frame
                if (s_axis_video_tvalid_in && s_axis_video_tuser_in) begin
                    if (at_origin) resync = load_en;
                    else           e_sf   = load_en;
                end else begin
                    s_axis_video_tready_out = load_en;
                    drop_end = load_en & s_axis_video_tvalid_in & s_axis_video_tlast_in;
                end
            end
        endcase
    end

    // Next state from the beat classification
    always_comb begin
        nxt_state = state;
        nxt_mode  = pad_mode;
        unique case (state)
            SEEK: begin
                if (e_sl) begin
                    nxt_state = PAD;
                    nxt_mode  = PAD_LINE;
                end else if (emit) begin
                    nxt_state = PASS;
                end
            end
            PASS: begin
                if (e_sf) begin
                    nxt_state = PAD;
                    nxt_mode  = PAD_FRAME;
                end else if (e_sl) begin
                    nxt_state = PAD;
                    nxt_mode  = PAD_LINE;
                end else if (e_ll) begin
                    nxt_state = DROP;
                end else if (e_lf) begin
                    nxt_state = SEEK;
                end
            end
            PAD: begin
                if (emit && x_last && (pad_mode == PAD_LINE || y_last)) nxt_state = PASS;
            end
            DROP: begin
                if (e_sf) begin
                    nxt_state = PAD;
                    nxt_mode  = PAD_FRAME;
                end else if (resync || drop_end) begin
                    nxt_state = PASS;
                end
            end
        endcase
    end

    // Pixel/line position of the next emitted beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
        end else if (emit) begin
            x <= x_last ? '0 : x + 1'b1;
            if (x_last) y <= y_last ? '0 : y + 1'b1;
        end
    end

    // Error flags line up with the cycle the offending beat is decided
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_short_line  <= 1'b0;
            err_long_line   <= 1'b0;
            err_short_frame <= 1'b0;
            err_long_frame  <= 1'b0;
        end else begin
            err_short_line  <= e_sl;
            err_long_line   <= e_ll;
            err_short_frame <= e_sf;
            err_long_frame  <= e_lf;
        end
    end

    axis_video_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .aclken    (aclken),
        .load_en   (load_en),
        .up_tvalid (emit),
        .up_tdata  (emit_data),
        .up_tuser  (at_origin),
        .up_tlast  (x_last),
        .dn_tready (m_axis_video_tready_in),
        .dn_tvalid (m_axis_video_tvalid_out),
        .dn_tdata  (m_axis_video_tdata_out),
        .dn_tuser  (m_axis_video_tuser_out),
        .dn_tlast  (m_axis_video_tlast_out)
    );

endmodule

// File: tb/tb_keystone_frame_regulator.sv
// tb/tb_keystone_frame_regulator.sv - directed self-checking bench for keystone_frame_regulator
module tb_keystone_frame_regulator;

    localparam logic [23:0] FILL = 24'h0000FF;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        aclken;
    logic [23:0] s_data;
    logic        s_valid, s_ready, s_user, s_last;
    logic [23:0] m_data;
    logic        m_valid, m_ready, m_user, m_last;
    logic        e_sl, e_ll, e_sf, e_lf;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    bp       = 1'b0;
    int    cycles   = 0;
    int    stall    = 0;
    int    c_sl = 0, c_ll = 0, c_sf = 0, c_lf = 0;
    int    c0;

    keystone_frame_regulator #(
        .DATA_W     (24),
        .H_ACTIVE   (4),
        .V_ACTIVE   (3),
        .FILL_COLOR (FILL)
    ) dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .aclken                  (aclken),
        .s_axis_video_tdata_in   (s_data),
        .s_axis_video_tvalid_in  (s_valid),
        .s_axis_video_tready_out (s_ready),
        .s_axis_video_tuser_in   (s_user),
        .s_axis_video_tlast_in   (s_last),
        .m_axis_video_tdata_out  (m_data),
        .m_axis_video_tvalid_out (m_valid),
        .m_axis_video_tready_in  (m_ready),
        .m_axis_video_tuser_out  (m_user),
        .m_axis_video_tlast_out  (m_last),
        .err_short_line          (e_sl),
        .err_long_line           (e_ll),
        .err_short_frame         (e_sf),
        .err_long_frame          (e_lf)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        exp_q.push_back(b);
    endtask

    // One clock: called at posedge+1 with inputs already driven, returns at next posedge+1
    task automatic cyc(output bit acc);
        beat_t e;
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        acc = s_valid && s_ready;
        if (s_valid && !s_ready) stall++;
        c_sl += int'(e_sl);
        c_ll += int'(e_ll);
        c_sf += int'(e_sf);
        c_lf += int'(e_lf);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {31'd0, m_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                check("out_data", {8'd0, m_data}, {8'd0, e.d});
                check("out_user", {31'd0, m_user}, {31'd0, e.u});
                check("out_last", {31'd0, m_last}, {31'd0, e.l});
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        cycles++;
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic u, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
        while (!acc && n < 200) begin
            cyc(acc);
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    endtask

    task automatic pass_beat(input logic [23:0] d, input logic u, input logic l);
        push(d, u, l);
        send(d, u, l);
    endtask

    task automatic send_frame(input logic [23:0] base);
        for (int i = 0; i < 12; i++) pass_beat(base + 24'(i), i == 0, (i % 4) == 3);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            cyc(acc);
            n++;
        end
        for (int i = 0; i < 3; i++) cyc(acc);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clr_err();
        c_sl = 0; c_ll = 0; c_sf = 0; c_lf = 0;
    endtask

    task automatic chk_err(input string tag, input int sl, input int ll, input int sf, input int lf);
        check({tag, "_short_line"},  32'(c_sl), 32'(sl));
        check({tag, "_long_line"},   32'(c_ll), 32'(ll));
        check({tag, "_short_frame"}, 32'(c_sf), 32'(sf));
        check({tag, "_long_frame"},  32'(c_lf), 32'(lf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; aclken = 1'b1;
        s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data",  {8'd0, m_data},   32'd0);
        check("rst_user",  {31'd0, m_user},  32'd0);
        check("rst_last",  {31'd0, m_last},  32'd0);
        check("rst_err",   {28'd0, e_sl, e_ll, e_sf, e_lf}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("seek_ready", {31'd0, s_ready}, 32'd1);

        // Clean frame: pass-through, one-cycle latency, no bubbles
        clr_err();
        c0 = cycles;
        for (int i = 0; i < 12; i++) begin
            pass_beat(24'h110000 + 24'(i), i == 0, (i % 4) == 3);
            if (i == 0) begin
                check("lat_valid", {31'd0, m_valid}, 32'd1);
                check("lat_data",  {8'd0, m_data},   32'h00110000);
                check("lat_user",  {31'd0, m_user},  32'd1);
            end
        end
        check("throughput", 32'(cycles - c0), 32'd12);
        drain();
        chk_err("clean", 0, 0, 0, 0);

        // Short second line padded with fill colour
        bp = 1'b1;
        clr_err();
        for (int i = 0; i < 4; i++) pass_beat(24'h220000 + 24'(i), i == 0, i == 3);
        pass_beat(24'h220010, 1'b0, 1'b0);
        push(24'h220011, 1'b0, 1'b0);
        send(24'h220011, 1'b0, 1'b1);
        push(FILL, 1'b0, 1'b0);
        push(FILL, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pass_beat(24'h220020 + 24'(i), 1'b0, i == 3);
        drain();
        chk_err("sline", 1, 0, 0, 0);

        // Long second line: cut at four, excess dropped
        clr_err();
        for (int i = 0; i < 4; i++) pass_beat(24'h330000 + 24'(i), i == 0, i == 3);
        for (int i = 0; i < 3; i++) pass_beat(24'h330010 + 24'(i), 1'b0, 1'b0);
        push(24'h330013, 1'b0, 1'b1);
        send(24'h330013, 1'b0, 1'b0);
        send(24'h330014, 1'b0, 1'b0);
        send(24'h330015, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pass_beat(24'h330020 + 24'(i), 1'b0, i == 3);
        drain();
        chk_err("lline", 0, 1, 0, 0);

        // Short frame: early tuser after 7 beats, 5 fill beats, input stalled meanwhile
        bp = 1'b0;
        clr_err();
        for (int i = 0; i < 4; i++) pass_beat(24'h440000 + 24'(i), i == 0, i == 3);
        for (int i = 0; i < 3; i++) pass_beat(24'h440010 + 24'(i), 1'b0, 1'b0);
        push(FILL, 1'b0, 1'b1);
        push(FILL, 1'b0, 1'b0);
        push(FILL, 1'b0, 1'b0);
        push(FILL, 1'b0, 1'b0);
        push(FILL, 1'b0, 1'b1);
        stall = 0;
        pass_beat(24'h450000, 1'b1, 1'b0);
        check("pad_stall", 32'(stall), 32'd6);
        for (int i = 1; i < 12; i++) pass_beat(24'h450000 + 24'(i), 1'b0, (i % 4) == 3);
        drain();
        chk_err("sframe", 0, 0, 1, 0);

        // Long frame under random backpressure: beat 13 dropped, resync on next tuser
        bp = 1'b1;
        clr_err();
        send_frame(24'h550000);
        send(24'h55FFFF, 1'b0, 1'b0);
        send(24'h56AAAA, 1'b0, 1'b1);
        send(24'h56BBBB, 1'b0, 1'b0);
        send_frame(24'h570000);
        drain();
        chk_err("lframe", 0, 0, 0, 1);

        // Reset in the middle of line two discards the held beat
        bp = 1'b0;
        clr_err();
        for (int i = 0; i < 4; i++) pass_beat(24'h660000 + 24'(i), i == 0, i == 3);
        pass_beat(24'h660010, 1'b0, 1'b0);
        pass_beat(24'h660011, 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data",  {8'd0, m_data},   32'd0);
        exp_q.delete();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        send(24'h66AAAA, 1'b0, 1'b0);
        send(24'h66BBBB, 1'b0, 1'b1);

        // Clock enable low for five cycles mid-frame freezes everything
        for (int i = 0; i < 6; i++) pass_beat(24'h770000 + 24'(i), i == 0, (i % 4) == 3);
        s_data = 24'h770006; s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        aclken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            check("frz_valid", {31'd0, m_valid}, 32'd1);
            check("frz_data",  {8'd0, m_data},   32'h00770005);
            check("frz_last",  {31'd0, m_last},  32'd0);
            check("frz_ready", {31'd0, s_ready}, 32'd0);
        end
        aclken = 1'b1;
        for (int i = 6; i < 12; i++) pass_beat(24'h770000 + 24'(i), 1'b0, (i % 4) == 3);
        drain();
        chk_err("rst_frz", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
